// File: rtl/alu_serial_sequencer.sv
// alu_serial_sequencer: bit-serial ALU, one 1-bit slice per clock LSB-first, with slt fix-up and DONE pulse
module alu_serial_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DN} state_t;
  state_t st;
  logic [WIDTH-1:0] ra, rb, sh, nxt;
  logic [2:0] rop;
  logic [CW-1:0] cnt;
  logic cy, cin_msb, sum_msb, ai, bi, s, co, bitv;
  logic unused_op3;
  assign unused_op3 = op[3];
  // in FIX, cy already holds the MSB carry-out, so cin_msb ^ cy is the overflow
  always_comb begin
    ai = ra[cnt];
    bi = rb[cnt] ^ rop[2];
    s = ai ^ bi ^ cy;
    co = (ai & bi) | (cy & (ai ^ bi));
    bitv = rop[1:0] == 2'b00 ? s : rop[1:0] == 2'b01 ? ai & bi : rop[1:0] == 2'b10 ? ai | bi : 1'b0;
    nxt = sh;
    nxt[cnt] = bitv;
    if (st == FIX) nxt = {sh[WIDTH-1:1], sum_msb ^ cin_msb ^ cy};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      zero <= 1'b0;
      cout <= 1'b0;
      ovf <= 1'b0;
      ra <= '0;
      rb <= '0;
      rop <= '0;
      cnt <= '0;
      cy <= 1'b0;
      cin_msb <= 1'b0;
      sum_msb <= 1'b0;
      sh <= '0;
    end else begin
      case (st)
        IDLE, DN: begin
          done <= 1'b0;
          st <= IDLE;
          if (start) begin
            ra <= a;
            rb <= b;
            rop <= op[2:0];
            cnt <= '0;
            cy <= op[2];
            sh <= '0;
            busy <= 1'b1;
            st <= RUN;
          end
        end
        RUN: begin
          sh <= nxt;
          cy <= co;
          if (cnt == LAST) begin
            cin_msb <= cy;
            sum_msb <= s;
            if (rop[1:0] == 2'b11) st <= FIX;
            else begin
              st <= DN;
              busy <= 1'b0;
              done <= 1'b1;
              result <= nxt;
              zero <= ~|nxt;
              cout <= co;
              ovf <= cy ^ co;
            end
          end else cnt <= cnt + CW'(1);
        end
        FIX: begin
          sh <= nxt;
          st <= DN;
          busy <= 1'b0;
          done <= 1'b1;
          result <= nxt;
          zero <= ~|nxt;
          cout <= cy;
          ovf <= cin_msb ^ cy;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_serial_sequencer.sv
// tb_alu_serial_sequencer: directed vectors with a scoreboard queue checked by a DONE monitor
module tb_alu_serial_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [3:0] op = '0;
  logic [7:0] a = '0, b = '0;
  logic busy, done, zero, cout, ovf;
  logic [7:0] result;
  typedef struct {logic [7:0] r; logic z, c, o; int t;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0;

  alu_serial_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("result", int'(result), int'(e.r));
        chk("zero", int'(zero), int'(e.z));
        chk("cout", int'(cout), int'(e.c));
        chk("ovf", int'(ovf), int'(e.o));
        chk("done_cycle", cyc, e.t);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  // called just after a falling edge; the next rising edge accepts START
  task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] r, input logic z, input logic c, input logic v);
    exp_t e;
    op = o; a = x; b = y; start = 1'b1;
    e.r = r; e.z = z; e.c = c; e.o = v;
    e.t = cyc + 1 + ((o[1:0] == 2'b11) ? 9 : 8);
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      @(negedge clk);
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic run(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] r, input logic z, input logic c, input logic v);
    issue(o, x, y, r, z, c, v);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_zero", int'(zero), 0);
    chk("rst_flags", int'({cout, ovf}), 0);
    run(4'b0000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    run(4'b0100, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1);
    run(4'b0001, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b1, 1'b0);
    run(4'b0010, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b1, 1'b0);
    run(4'b0111, 8'h05, 8'h03, 8'h00, 1'b1, 1'b1, 1'b0);
    run(4'b1111, 8'h80, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b1);
    issue(4'b0000, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("hold_result", int'(result), 8'h01);
    chk("busy_running", int'(busy), 1);
    op = 4'b0001; a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    issue(4'b0100, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1);
    wait_done();
    @(negedge clk);
    issue(4'b0000, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
    void'(q.pop_back());
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_flags", int'({zero, cout, ovf}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_idle_busy", int'(busy), 0);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
